// File: rtl/uart_alu_sequencer.sv
// uart_alu_sequencer: pulls A, B and opcode bytes from the RX FIFO, holds them
// on the ALU inputs, waits ALU_LAT cycles, then pushes the result to TX FIFO.
// Optional build macro: SEQ_TIMEOUT_EN (inter-byte timeout in GET_B/GET_OP).
module uart_alu_sequencer #(
   parameter int DATA_W         = 8,
   parameter int OP_W           = DATA_W - 2,
   parameter int ALU_LAT        = 1,
   parameter int TIMEOUT_CYCLES = 1000
) (
   input  logic              clk,
   input  logic              i_reset,
   input  logic [DATA_W-1:0] i_rx_data,
   input  logic              i_rx_empty,
   output logic              o_rx_rd,
   output logic [DATA_W-1:0] o_opA,
   output logic [DATA_W-1:0] o_opB,
   output logic [OP_W-1:0]   o_opCode,
   input  logic [DATA_W-1:0] i_alu_result,
   output logic [DATA_W-1:0] o_tx_data,
   input  logic              i_tx_full,
   output logic              o_tx_wr,
   output logic              o_busy,
   output logic              o_timeout,
   output logic [7:0]        o_frame_cnt
);

   localparam int LAT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
   localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(ALU_LAT - 1);

   typedef enum logic [2:0] {GET_A, GET_B, GET_OP, EXEC, SEND} state_t;

   state_t            r_state, w_next;
   logic [DATA_W-1:0] r_opA, r_opB, r_tx_data;
   logic [OP_W-1:0]   r_opCode;
   logic [LAT_W-1:0]  r_lat;
   logic [7:0]        r_frame_cnt;
   logic              r_busy;
   logic              w_pop, w_push, w_to;

`ifdef SEQ_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [TO_W-1:0] r_to_cnt;
   logic            w_to_hit;

   // Terminal count is reached in the empty cycle that would bring the count to TIMEOUT_CYCLES.
   assign w_to_hit = i_rx_empty && (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

   // Inter-byte idle counter: runs only while waiting on B or opcode, clears on pop/abort.
   always_ff @(posedge clk or negedge i_reset) begin
      if (!i_reset)
         r_to_cnt <= '0;
      else if ((r_state == GET_B || r_state == GET_OP) && i_rx_empty && !w_to)
         r_to_cnt <= r_to_cnt + 1'b1;
      else
         r_to_cnt <= '0;
   end
`endif

   // Next-state and handshake strobes; a pop always wins over a timeout.
   always_comb begin
      w_next = r_state;
      w_pop  = 1'b0;
      w_push = 1'b0;
      w_to   = 1'b0;
      case (r_state)
         GET_A: begin
            w_pop = !i_rx_empty;
            if (w_pop) w_next = GET_B;
         end
         GET_B, GET_OP: begin
            w_pop = !i_rx_empty;
            if (w_pop)
               w_next = (r_state == GET_B) ? GET_OP : EXEC;
`ifdef SEQ_TIMEOUT_EN
            else if (w_to_hit) begin
               w_to   = 1'b1;
               w_next = GET_A;
            end
`endif
         end
         EXEC: begin
            if (r_lat == '0) w_next = SEND;
         end
         SEND: begin
            w_push = !i_tx_full;
            if (w_push) w_next = GET_A;
         end
         default: w_next = GET_A;
      endcase
   end

   // State register; busy is registered from the next state so it tracks the state one-for-one.
   always_ff @(posedge clk or negedge i_reset) begin
      if (!i_reset) begin
         r_state <= GET_A;
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_next;
         r_busy  <= (w_next != GET_A);
      end
   end

   // Operand capture on each pop; values persist after the frame so the ALU inputs stay stable.
   always_ff @(posedge clk or negedge i_reset) begin
      if (!i_reset) begin
         r_opA    <= '0;
         r_opB    <= '0;
         r_opCode <= '0;
      end else if (w_pop) begin
         if (r_state == GET_A)  r_opA    <= i_rx_data;
         if (r_state == GET_B)  r_opB    <= i_rx_data;
         if (r_state == GET_OP) r_opCode <= i_rx_data[OP_W-1:0];
      end
   end

   // ALU latency counter: loaded on the opcode pop, counts down through EXEC.
   always_ff @(posedge clk or negedge i_reset) begin
      if (!i_reset)
         r_lat <= '0;
      else if (w_pop && r_state == GET_OP)
         r_lat <= LAT_INIT;
      else if (r_state == EXEC && r_lat != '0)
         r_lat <= r_lat - 1'b1;
   end

   // Result capture at the end of EXEC; held through SEND until the push.
   always_ff @(posedge clk or negedge i_reset) begin
      if (!i_reset)
         r_tx_data <= '0;
      else if (r_state == EXEC && r_lat == '0)
         r_tx_data <= i_alu_result;
   end

   // Completed-frame counter, wraps naturally at 8 bits.
   always_ff @(posedge clk or negedge i_reset) begin
      if (!i_reset)
         r_frame_cnt <= '0;
      else if (w_push)
         r_frame_cnt <= r_frame_cnt + 8'd1;
   end

   assign o_rx_rd     = w_pop;
   assign o_tx_wr     = w_push;
   assign o_timeout   = w_to;
   assign o_opA       = r_opA;
   assign o_opB       = r_opB;
   assign o_opCode    = r_opCode;
   assign o_tx_data   = r_tx_data;
   assign o_busy      = r_busy;
   assign o_frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_uart_alu_sequencer.sv
// Bench for uart_alu_sequencer: RX FIFO model feeds bytes, ALU model is A+B,
// expected TX bytes are queued at stimulus time and checked at each push.
module tb_uart_alu_sequencer;

   localparam int DATA_W = 8;
   localparam int OP_W   = 6;
   localparam int TO_CYC = 16;

   logic              clk = 1'b0;
   logic              i_reset;
   logic [DATA_W-1:0] i_rx_data = '0;
   logic              i_rx_empty = 1'b1;
   logic              o_rx_rd;
   logic [DATA_W-1:0] o_opA, o_opB, o_tx_data, alu_result;
   logic [OP_W-1:0]   o_opCode;
   logic              i_tx_full;
   logic              o_tx_wr, o_busy, o_timeout;
   logic [7:0]        o_frame_cnt;

   uart_alu_sequencer #(.DATA_W(DATA_W), .OP_W(OP_W), .ALU_LAT(1), .TIMEOUT_CYCLES(TO_CYC)) dut (
      .clk(clk), .i_reset(i_reset), .i_rx_data(i_rx_data), .i_rx_empty(i_rx_empty),
      .o_rx_rd(o_rx_rd), .o_opA(o_opA), .o_opB(o_opB), .o_opCode(o_opCode),
      .i_alu_result(alu_result), .o_tx_data(o_tx_data), .i_tx_full(i_tx_full),
      .o_tx_wr(o_tx_wr), .o_busy(o_busy), .o_timeout(o_timeout), .o_frame_cnt(o_frame_cnt)
   );

   always #5 clk = ~clk;

   // ALU model: combinational sum of the held operands
   assign alu_result = o_opA + o_opB;

   logic [7:0] rx_q[$];
   logic [7:0] exp_q[$];
   int         pop_cyc_q[$];
   int         cyc = 0, n_push = 0, push_cyc = 0, to_pulses = 0, to_cyc = 0, n_frames = 0;
   int         n_chk = 0, n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op);
      rx_q.push_back(a);
      rx_q.push_back(b);
      rx_q.push_back(op);
      exp_q.push_back(a + b);
      n_frames++;
   endtask

   task automatic wait_drain(input int budget);
      int k = 0;
      while ((exp_q.size() != 0 || rx_q.size() != 0) && k < budget) begin
         tick(1);
         k++;
      end
      if (k >= budget) chk("drain_timeout", 0, 1);
      tick(2);
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // RX FIFO model: first-word-fall-through, pops the head after a cycle in which o_rx_rd was high
   always begin : rx_fifo
      logic pend;
      @(negedge clk);
      pend = o_rx_rd;
      @(posedge clk);
      #2;
      if (pend && rx_q.size() > 0) void'(rx_q.pop_front());
      if (rx_q.size() > 0) begin
         i_rx_empty = 1'b0;
         i_rx_data  = rx_q[0];
      end else begin
         i_rx_empty = 1'b1;
      end
   end

   // Monitor / scoreboard, sampled mid-cycle
   always @(negedge clk) begin
      if (i_reset) begin
         if (o_rx_rd) pop_cyc_q.push_back(cyc);
         if (o_timeout) begin
            to_pulses++;
            to_cyc = cyc;
         end
         if (o_tx_wr) begin
            n_push++;
            push_cyc = cyc;
            if (exp_q.size() == 0) chk("tx_unexpected", 1, 0);
            else chk("tx_data", o_tx_data, exp_q.pop_front());
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int p0;
      i_reset   = 1'b0;
      i_tx_full = 1'b0;
      tick(3);
      chk("rst_opA", o_opA, 0);
      chk("rst_opB", o_opB, 0);
      chk("rst_opCode", o_opCode, 0);
      chk("rst_tx_data", o_tx_data, 0);
      chk("rst_frame_cnt", o_frame_cnt, 0);
      chk("rst_rx_rd", o_rx_rd, 0);
      chk("rst_tx_wr", o_tx_wr, 0);
      chk("rst_timeout", o_timeout, 0);
      chk("rst_busy", o_busy, 0);
      i_reset = 1'b1;
      tick(2);

      // back-to-back frame: pops at 0,1,2, push at 4
      pop_cyc_q.delete();
      send_frame(8'h05, 8'h03, 8'h20);
      wait_drain(50);
      chk("t1_opA", o_opA, 8'h05);
      chk("t1_opB", o_opB, 8'h03);
      chk("t1_opCode", o_opCode, 8'h20);
      chk("t1_frame_cnt", o_frame_cnt, 1);
      chk("t1_pops", pop_cyc_q.size(), 3);
      if (pop_cyc_q.size() >= 3) begin
         p0 = pop_cyc_q[0];
         chk("t1_pop1_cyc", pop_cyc_q[1] - p0, 1);
         chk("t1_pop2_cyc", pop_cyc_q[2] - p0, 2);
         chk("t1_push_cyc", push_cyc - p0, 4);
      end
      chk("t1_idle_busy", o_busy, 0);

      // TX full holds the result; the following frame's bytes stay in RX
      i_tx_full = 1'b1;
      p0 = n_push;
      pop_cyc_q.delete();
      send_frame(8'h10, 8'h20, 8'h01);
      send_frame(8'h07, 8'h08, 8'h09);
      tick(6);
      chk("t2_hold_data_a", o_tx_data, 8'h30);
      tick(10);
      chk("t2_hold_data_b", o_tx_data, 8'h30);
      chk("t2_hold_pops", pop_cyc_q.size(), 3);
      chk("t2_hold_pushes", n_push - p0, 0);
      chk("t2_hold_busy", o_busy, 1);
      i_tx_full = 1'b0;
      wait_drain(50);
      chk("t2_pushes", n_push - p0, 2);
      chk("t2_frame_cnt", o_frame_cnt, 8'(n_frames));

      // one-cycle gaps between bytes, opcode truncated to 6 bits
      pop_cyc_q.delete();
      rx_q.push_back(8'hFF);
      tick(2);
      rx_q.push_back(8'h01);
      tick(2);
      rx_q.push_back(8'h3F);
      exp_q.push_back(8'h00);
      n_frames++;
      wait_drain(50);
      chk("t3_opA", o_opA, 8'hFF);
      chk("t3_opB", o_opB, 8'h01);
      chk("t3_opCode", o_opCode, 8'h3F);
      chk("t3_pops", pop_cyc_q.size(), 3);
      if (pop_cyc_q.size() >= 3) chk("t3_pop_span", pop_cyc_q[2] - pop_cyc_q[0], 4);
      chk("t3_frame_cnt", o_frame_cnt, 8'(n_frames));

      // reset while waiting for the opcode discards the partial frame
      rx_q.push_back(8'h11);
      rx_q.push_back(8'h22);
      tick(6);
      chk("t4_pre_opA", o_opA, 8'h11);
      chk("t4_pre_opB", o_opB, 8'h22);
      chk("t4_pre_busy", o_busy, 1);
      i_reset = 1'b0;
      #1;
      chk("t4_opA", o_opA, 0);
      chk("t4_opB", o_opB, 0);
      chk("t4_opCode", o_opCode, 0);
      chk("t4_tx_data", o_tx_data, 0);
      chk("t4_frame_cnt", o_frame_cnt, 0);
      chk("t4_busy", o_busy, 0);
      tick(1);
      i_reset  = 1'b1;
      n_frames = 0;
      tick(1);
      send_frame(8'h04, 8'h05, 8'h06);
      wait_drain(50);
      chk("t4_new_opA", o_opA, 8'h04);
      chk("t4_new_opCode", o_opCode, 8'h06);
      chk("t4_new_frame_cnt", o_frame_cnt, 1);

      // lone byte then idle
      to_pulses = 0;
      p0 = n_push;
      pop_cyc_q.delete();
      rx_q.push_back(8'h0A);
      tick(40);
      chk("t5_pushes", n_push - p0, 0);
      chk("t5_frame_cnt", o_frame_cnt, 1);
`ifdef SEQ_TIMEOUT_EN
      chk("t5_to_pulses", to_pulses, 1);
      if (pop_cyc_q.size() >= 1) chk("t5_to_delay", to_cyc - pop_cyc_q[0], TO_CYC);
      chk("t5_busy", o_busy, 0);
      send_frame(8'h01, 8'h02, 8'h03);
      wait_drain(50);
      chk("t5_opA", o_opA, 8'h01);
`else
      chk("t5_to_pulses", to_pulses, 0);
      chk("t5_busy", o_busy, 1);
      rx_q.push_back(8'h02);
      rx_q.push_back(8'h03);
      exp_q.push_back(8'h0C);
      n_frames++;
      wait_drain(50);
      chk("t5_opA", o_opA, 8'h0A);
`endif
      chk("t5_after_frame_cnt", o_frame_cnt, 2);

      // run up to 255 frames, then the 256th wraps the counter to 0
      while (n_frames < 255)
         send_frame(8'($urandom), 8'($urandom), 8'($urandom));
      wait_drain(5000);
      chk("t6_cnt_255", o_frame_cnt, 255);
      send_frame(8'h12, 8'h34, 8'hC5);
      wait_drain(50);
      chk("t6_cnt_wrap", o_frame_cnt, 0);
      chk("t6_opCode_trunc", o_opCode, 8'h05);
      chk("t6_scoreboard_empty", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
